// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: opcodes, functs,
// ALU/mux select codes and the controller state type.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      SRCB_RT      = 2'b00,
      SRCB_FOUR    = 2'b01,
      SRCB_IMM     = 2'b10,
      SRCB_IMM_SH2 = 2'b11
   } src_b_e;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10
   } pc_src_e;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB,
      S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP, S_ERROR
   } state_e;

   // States that wait on the memory handshake and are guarded by the timeout
   function automatic logic is_mem_state(input state_e s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle. master = controller side,
// slave = datapath/memory side.
interface multicycle_control_if #(
   parameter int CNT_W = 32
);
   logic             start;
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             mem_ready;
   logic             pc_write;
   logic             pc_write_cond;
   logic [1:0]       pc_source;
   logic             i_or_d;
   logic             mem_read;
   logic             mem_write;
   logic             ir_write;
   logic             reg_dst;
   logic             mem_to_reg;
   logic             reg_write;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [3:0]       alu_ctrl;
   logic             busy;
   logic             retired;
   logic [CNT_W-1:0] instr_count;
   logic             illegal_op;
   logic             bus_error;

   modport master (
      input  start, opcode, funct, mem_ready,
      output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
             alu_ctrl, busy, retired, instr_count, illegal_op, bus_error
   );

   modport slave (
      output start, opcode, funct, mem_ready,
      input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
             alu_ctrl, busy, retired, instr_count, illegal_op, bus_error
   );
endinterface

// File: rtl/alu_decoder.sv
// R-type funct decoder: ALU operation plus a legality flag for the supported
// funct subset.
module alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] i_funct,
   output alu_ctrl_e  o_alu_ctrl,
   output logic       o_legal
);

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      o_alu_ctrl = ALU_ADD;
      o_legal    = 1'b1;
      case (i_funct)
         FN_ADD:  o_alu_ctrl = ALU_ADD;
         FN_SUB:  o_alu_ctrl = ALU_SUB;
         FN_AND:  o_alu_ctrl = ALU_AND;
         FN_OR:   o_alu_ctrl = ALU_OR;
         FN_SLT:  o_alu_ctrl = ALU_SLT;
         default: o_legal    = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/mem/writeback,
// counts retired instructions and traps illegal opcodes and memory timeouts.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input logic                  clock,
   input logic                  reset,
   multicycle_control_if.master bus
);

   localparam int              WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_e             r_state;
   state_e             w_next;
   logic [WAIT_W-1:0]  r_wait;
   logic [CNT_W-1:0]   r_instr_count;
   alu_ctrl_e          w_dec_ctrl;
   logic               w_dec_legal;
   logic               w_timeout;
   logic               w_retire;
   logic               w_illegal;

   alu_decoder u_alu_decoder (
      .i_funct    (bus.funct),
      .o_alu_ctrl (w_dec_ctrl),
      .o_legal    (w_dec_legal)
   );

   // Last allowed wait cycle still without mem_ready
   assign w_timeout = is_mem_state(r_state) && !bus.mem_ready && (r_wait == WAIT_LAST);

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_wait        <= '0;
         r_instr_count <= '0;
      end else begin
         r_state <= w_next;
         if (is_mem_state(r_state) && !bus.mem_ready) r_wait <= r_wait + 1'b1;
         else                                         r_wait <= '0;
         if (w_retire) r_instr_count <= r_instr_count + 1'b1;
      end
   end

   always_comb begin
      w_next            = r_state;
      w_retire          = 1'b0;
      w_illegal         = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.pc_source     = PCSRC_ALU;
      bus.i_or_d        = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = SRCB_RT;
      bus.alu_ctrl      = ALU_AND;

      case (r_state)
         S_IDLE: if (bus.start) w_next = S_FETCH;
         S_FETCH: begin
            bus.mem_read = 1'b1;
            if (bus.mem_ready) begin
               bus.ir_write  = 1'b1;
               bus.pc_write  = 1'b1;
               bus.alu_src_b = SRCB_FOUR;
               bus.alu_ctrl  = ALU_ADD;
               w_next        = S_DECODE;
            end else if (w_timeout) begin
               w_next = S_ERROR;
            end
         end
         S_DECODE: begin
            bus.alu_src_b = SRCB_IMM_SH2;
            bus.alu_ctrl  = ALU_ADD;
            case (bus.opcode)
               OP_RTYPE:     if (w_dec_legal) w_next = S_EXEC_R; else w_illegal = 1'b1;
               OP_ADDI:      w_next = S_EXEC_I;
               OP_LW, OP_SW: w_next = S_MEM_ADDR;
               OP_BEQ:       w_next = S_BRANCH;
               OP_J:         w_next = S_JUMP;
               default:      w_illegal = 1'b1;
            endcase
         end
         S_EXEC_R: begin
            bus.alu_src_a = 1'b1;
            bus.alu_ctrl  = w_dec_ctrl;
            w_next        = S_R_WB;
         end
         S_R_WB: begin
            bus.reg_dst   = 1'b1;
            bus.reg_write = 1'b1;
            w_retire      = 1'b1;
         end
         S_EXEC_I: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = SRCB_IMM;
            bus.alu_ctrl  = ALU_ADD;
            w_next        = S_I_WB;
         end
         S_I_WB: begin
            bus.reg_write = 1'b1;
            w_retire      = 1'b1;
         end
         S_MEM_ADDR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = SRCB_IMM;
            bus.alu_ctrl  = ALU_ADD;
            w_next        = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            bus.mem_read = 1'b1;
            bus.i_or_d   = 1'b1;
            if (bus.mem_ready)  w_next = S_MEM_WB;
            else if (w_timeout) w_next = S_ERROR;
         end
         S_MEM_WB: begin
            bus.mem_to_reg = 1'b1;
            bus.reg_write  = 1'b1;
            w_retire       = 1'b1;
         end
         S_MEM_WRITE: begin
            bus.mem_write = 1'b1;
            bus.i_or_d    = 1'b1;
            if (bus.mem_ready)  w_retire = 1'b1;
            else if (w_timeout) w_next   = S_ERROR;
         end
         S_BRANCH: begin
            bus.alu_src_a     = 1'b1;
            bus.alu_ctrl      = ALU_SUB;
            bus.pc_write_cond = 1'b1;
            bus.pc_source     = PCSRC_ALUOUT;
            w_retire          = 1'b1;
         end
         S_JUMP: begin
            bus.pc_write  = 1'b1;
            bus.pc_source = PCSRC_JUMP;
            w_retire      = 1'b1;
         end
         S_ERROR: w_next = S_ERROR;
         default: w_next = S_IDLE;
      endcase

      // start is only sampled at an instruction boundary
      if (w_retire || w_illegal) w_next = bus.start ? S_FETCH : S_IDLE;
   end

   assign bus.retired     = w_retire;
   assign bus.illegal_op  = w_illegal;
   assign bus.busy        = (r_state != S_IDLE) && (r_state != S_ERROR);
   assign bus.bus_error   = (r_state == S_ERROR);
   assign bus.instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: inputs change 1ns after the rising
// edge, outputs are compared once they have settled.
module tb_multicycle_control;

   logic clock;
   logic reset;
   int   n_assert;
   int   n_fail;
   int   exp_count;

   logic [5:0] fn_tab  [4] = '{6'h22, 6'h24, 6'h25, 6'h2A};
   logic [3:0] ctl_tab [4] = '{4'b0110, 4'b0000, 4'b0001, 4'b0111};

   multicycle_control_if #(.CNT_W(32)) bus ();

   multicycle_control #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Entered with the DUT in FETCH; completes the fetch and leaves it in DECODE.
   task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
      bus.opcode    = op;
      bus.funct     = fn;
      bus.mem_ready = 1'b1;
      #1;
      check("fetch_mem_read", bus.mem_read, 1'b1);
      check("fetch_ir_write", bus.ir_write, 1'b1);
      check("fetch_pc_write", bus.pc_write, 1'b1);
      tick();
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      exp_count = 0;
      reset         = 1'b1;
      bus.start     = 1'b1;
      bus.mem_ready = 1'b0;
      bus.opcode    = 6'h00;
      bus.funct     = 6'h00;
      repeat (2) tick();

      // Reset held with start high
      check("rst_busy", bus.busy, 1'b0);
      check("rst_mem_read", bus.mem_read, 1'b0);
      check("rst_pc_write", bus.pc_write, 1'b0);
      check("rst_alu_ctrl", bus.alu_ctrl, 4'b0000);
      check("rst_count", bus.instr_count, 32'd0);
      check("rst_bus_error", bus.bus_error, 1'b0);
      reset = 1'b0;
      #1;
      check("idle_busy", bus.busy, 1'b0);
      tick();
      check("fetch_entry_mem_read", bus.mem_read, 1'b1);
      check("fetch_entry_i_or_d", bus.i_or_d, 1'b0);
      check("fetch_entry_ir_write", bus.ir_write, 1'b0);
      check("fetch_entry_busy", bus.busy, 1'b1);

      // ADD
      fetch(6'h00, 6'h20);
      check("dec_src_b", bus.alu_src_b, 2'b11);
      check("dec_alu_ctrl", bus.alu_ctrl, 4'b0010);
      check("dec_illegal", bus.illegal_op, 1'b0);
      tick();
      check("add_exec_alu_ctrl", bus.alu_ctrl, 4'b0010);
      check("add_exec_src_a", bus.alu_src_a, 1'b1);
      check("add_exec_reg_write", bus.reg_write, 1'b0);
      tick();
      check("add_wb_reg_write", bus.reg_write, 1'b1);
      check("add_wb_reg_dst", bus.reg_dst, 1'b1);
      check("add_wb_retired", bus.retired, 1'b1);
      exp_count++;
      tick();
      check("add_count", bus.instr_count, exp_count);
      check("add_retired_pulse", bus.retired, 1'b0);

      // Remaining R-type functs
      for (int i = 0; i < 4; i++) begin
         fetch(6'h00, fn_tab[i]);
         tick();
         check("r_exec_alu_ctrl", bus.alu_ctrl, ctl_tab[i]);
         tick();
         check("r_wb_reg_write", bus.reg_write, 1'b1);
         exp_count++;
         tick();
         check("r_count", bus.instr_count, exp_count);
      end

      // LW with three not-ready cycles in MEM_READ
      fetch(6'h23, 6'h00);
      tick();
      check("lw_addr_src_a", bus.alu_src_a, 1'b1);
      check("lw_addr_src_b", bus.alu_src_b, 2'b10);
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("lw_wait_mem_read", bus.mem_read, 1'b1);
         check("lw_wait_i_or_d", bus.i_or_d, 1'b1);
         check("lw_wait_reg_write", bus.reg_write, 1'b0);
      end
      tick();
      bus.mem_ready = 1'b1;
      #1;
      check("lw_ready_mem_read", bus.mem_read, 1'b1);
      tick();
      check("lw_wb_reg_write", bus.reg_write, 1'b1);
      check("lw_wb_mem_to_reg", bus.mem_to_reg, 1'b1);
      check("lw_wb_reg_dst", bus.reg_dst, 1'b0);
      check("lw_wb_mem_read", bus.mem_read, 1'b0);
      exp_count++;
      tick();
      check("lw_count", bus.instr_count, exp_count);

      // BEQ
      fetch(6'h04, 6'h00);
      tick();
      check("beq_pc_write_cond", bus.pc_write_cond, 1'b1);
      check("beq_pc_source", bus.pc_source, 2'b01);
      check("beq_alu_ctrl", bus.alu_ctrl, 4'b0110);
      check("beq_pc_write", bus.pc_write, 1'b0);
      check("beq_retired", bus.retired, 1'b1);
      exp_count++;
      tick();

      // SW with two not-ready cycles
      fetch(6'h2B, 6'h00);
      tick();
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("sw_wait_mem_write", bus.mem_write, 1'b1);
         check("sw_wait_i_or_d", bus.i_or_d, 1'b1);
         check("sw_wait_retired", bus.retired, 1'b0);
      end
      bus.mem_ready = 1'b1;
      #1;
      check("sw_ready_mem_write", bus.mem_write, 1'b1);
      check("sw_ready_retired", bus.retired, 1'b1);
      exp_count++;
      tick();
      check("sw_done_mem_write", bus.mem_write, 1'b0);
      check("sw_count", bus.instr_count, exp_count);

      // J
      fetch(6'h02, 6'h00);
      tick();
      check("j_pc_write", bus.pc_write, 1'b1);
      check("j_pc_source", bus.pc_source, 2'b10);
      check("j_retired", bus.retired, 1'b1);
      exp_count++;
      tick();

      // ADDI
      fetch(6'h08, 6'h00);
      tick();
      check("addi_src_b", bus.alu_src_b, 2'b10);
      check("addi_alu_ctrl", bus.alu_ctrl, 4'b0010);
      tick();
      check("addi_reg_write", bus.reg_write, 1'b1);
      check("addi_reg_dst", bus.reg_dst, 1'b0);
      exp_count++;
      tick();
      check("addi_count", bus.instr_count, exp_count);

      // Illegal opcode with start dropped -> IDLE
      fetch(6'h3F, 6'h00);
      bus.start = 1'b0;
      #1;
      check("ill_op_pulse", bus.illegal_op, 1'b1);
      check("ill_op_reg_write", bus.reg_write, 1'b0);
      check("ill_op_mem_write", bus.mem_write, 1'b0);
      check("ill_op_retired", bus.retired, 1'b0);
      tick();
      check("ill_op_idle_busy", bus.busy, 1'b0);
      check("ill_op_pulse_end", bus.illegal_op, 1'b0);
      check("ill_op_count", bus.instr_count, exp_count);
      bus.start = 1'b1;
      tick();
      check("restart_mem_read", bus.mem_read, 1'b1);

      // Illegal R-type funct with start high -> straight back to FETCH
      fetch(6'h00, 6'h21);
      check("ill_fn_pulse", bus.illegal_op, 1'b1);
      tick();
      check("ill_fn_refetch", bus.mem_read, 1'b1);
      check("ill_fn_count", bus.instr_count, exp_count);

      // start dropped mid-instruction does not truncate it
      fetch(6'h08, 6'h00);
      bus.start = 1'b0;
      tick();
      check("drop_exec_busy", bus.busy, 1'b1);
      tick();
      check("drop_wb_retired", bus.retired, 1'b1);
      exp_count++;
      tick();
      check("drop_idle_busy", bus.busy, 1'b0);
      check("drop_count", bus.instr_count, exp_count);
      bus.start = 1'b1;
      tick();

      // LW with mem_ready on the 16th (last allowed) MEM_READ cycle
      fetch(6'h23, 6'h00);
      tick();
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      check("lw_edge_mem_read", bus.mem_read, 1'b1);
      tick();
      bus.mem_ready = 1'b1;
      #1;
      check("lw_edge_last_mem_read", bus.mem_read, 1'b1);
      tick();
      check("lw_edge_wb_reg_write", bus.reg_write, 1'b1);
      check("lw_edge_bus_error", bus.bus_error, 1'b0);
      exp_count++;
      tick();
      check("lw_edge_count", bus.instr_count, exp_count);

      // FETCH timeout: 16 not-ready cycles -> ERROR
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      check("to_last_mem_read", bus.mem_read, 1'b1);
      check("to_last_bus_error", bus.bus_error, 1'b0);
      tick();
      check("to_bus_error", bus.bus_error, 1'b1);
      check("to_busy", bus.busy, 1'b0);
      check("to_mem_read", bus.mem_read, 1'b0);
      bus.mem_ready = 1'b1;
      repeat (3) tick();
      check("to_sticky_bus_error", bus.bus_error, 1'b1);
      check("to_sticky_mem_read", bus.mem_read, 1'b0);
      check("to_sticky_ir_write", bus.ir_write, 1'b0);
      reset = 1'b1;
      #1;
      check("to_reset_bus_error", bus.bus_error, 1'b0);
      check("to_reset_count", bus.instr_count, 32'd0);
      reset = 1'b0;
      tick();
      check("to_restart_mem_read", bus.mem_read, 1'b1);

      // Reset mid-instruction aborts without the writeback strobe
      fetch(6'h00, 6'h20);
      tick();
      reset = 1'b1;
      #1;
      check("abort_busy", bus.busy, 1'b0);
      check("abort_src_a", bus.alu_src_a, 1'b0);
      tick();
      check("abort_reg_write", bus.reg_write, 1'b0);
      check("abort_retired", bus.retired, 1'b0);
      check("abort_count", bus.instr_count, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
